ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_host_tx_if.sv | 11 +
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common command bytes and
// frame helpers used by the host-to-device transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        START    = 3'd2,
        TX       = 3'd3,
        ACK      = 3'd4,
        WAIT_REL = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    // Index of the stop bit within the 11-bit frame; bitcnt stops one past it.
    localparam logic [3:0] PS2_STOP_IDX   = 4'd10;
    localparam logic [3:0] PS2_BITCNT_MAX = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame bit idx of {stop, parity, data[7:0], start}; beyond the stop bit the line idles high.
    function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] idx);
        logic [10:0] frame;
        logic        b;
        frame = {1'b1, p, d, 1'b0};
        if (idx <= PS2_STOP_IDX) begin
            b = frame[idx];
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output tx_data, output tx_start, input busy, input done, input err);
    modport slave  (input tx_data, input tx_start, output busy, output done, output err);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered falling-edge pulse.
// Shared by the receive and transmit paths.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic fall_r;

    // Synchronize the line and flag a 1->0 transition of the synced level; idle-high reset avoids a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else begin
            meta_r <= line_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
            fall_r <= prev_r & ~sync_r;
        end
    end

    assign level = sync_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte with
// odd parity, checks the device ACK and reports done or err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  cmd,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    import ps2_pkg::*;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    ps2_state_e       state_r, state_nxt_s;
    logic [3:0]       bitcnt_r, bitcnt_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       data_r;
    logic             par_r;

    logic clk_level_s, clk_fall_s;
    logic data_level_s, data_fall_unused_s;
    logic active_s, timeout_s;

    logic busy_s, clk_oe_s, data_oe_s, done_s, err_s;
    logic busy_r, clk_oe_r, data_oe_r, done_r, err_r;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .level   (clk_level_s),
        .fall    (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data_in),
        .level   (data_level_s),
        .fall    (data_fall_unused_s)
    );

    // The timeout window runs from START through WAIT_REL, counted by the shared cycle counter.
    assign active_s  = state_r inside {START, TX, ACK, WAIT_REL};
    assign timeout_s = active_s && (cnt_r == TO_LAST);

    // State, counters, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bitcnt_r  <= 4'd0;
            cnt_r     <= CNT_ZERO;
            data_r    <= 8'h00;
            par_r     <= 1'b0;
            busy_r    <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            bitcnt_r <= bitcnt_nxt_s;
            // Restart at IDLE and again on entering START so the timeout counts from the start bit.
            if ((state_r == IDLE) || (state_nxt_s == START)) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if ((state_r == IDLE) && cmd.tx_start) begin
                data_r <= cmd.tx_data;
                par_r  <= odd_parity(cmd.tx_data);
            end else begin
                data_r <= data_r;
                par_r  <= par_r;
            end
            busy_r    <= busy_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    // Next-state and bit-counter logic; timeout wins over any line activity.
    always_comb begin
        state_nxt_s  = state_r;
        bitcnt_nxt_s = bitcnt_r;
        case (state_r)
            IDLE: begin
                if (cmd.tx_start) begin
                    state_nxt_s = INHIBIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = INHIBIT;
                end
            end
            START: begin
                bitcnt_nxt_s = 4'd0;
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TX;
                end
            end
            TX: begin
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else if (clk_fall_s) begin
                    bitcnt_nxt_s = (bitcnt_r == PS2_BITCNT_MAX) ? bitcnt_r : bitcnt_r + 4'd1;
                    if (bitcnt_r == PS2_STOP_IDX) begin
                        state_nxt_s = ACK;
                    end else begin
                        state_nxt_s = TX;
                    end
                end else begin
                    state_nxt_s = TX;
                end
            end
            ACK: begin
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else if (!data_level_s) begin
                    state_nxt_s = WAIT_REL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_REL: begin
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else if (clk_level_s && data_level_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_REL;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                bitcnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is registered yet aligned with state_r.
    always_comb begin
        busy_s    = 1'b0;
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                // Leaving an active state: only a clean release from WAIT_REL counts as success.
                if (active_s) begin
                    if ((state_r == WAIT_REL) && !timeout_s) begin
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            INHIBIT: begin
                busy_s   = 1'b1;
                clk_oe_s = 1'b1;
            end
            START: begin
                busy_s    = 1'b1;
                clk_oe_s  = 1'b1;
                data_oe_s = 1'b1;
            end
            TX: begin
                busy_s    = 1'b1;
                data_oe_s = ~frame_bit(data_r, par_r, bitcnt_nxt_s);
            end
            ACK, WAIT_REL: begin
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign cmd.busy    = busy_r;
    assign cmd.done    = done_r;
    assign cmd.err     = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the frame
// and the expected line pattern is derived from the byte with plain arithmetic.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 1500;
    localparam int HP  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx_if cmd();
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_in, ps2_data_in;
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int pulse_viol = 0;
    int last_err_cyc = 0;
    int start_cyc = 0;

    // Pulse monitor: counts done/err and flags pulses that overlap busy, a held line or each other.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd.done === 1'b1) done_cnt <= done_cnt + 1;
            if (cmd.err === 1'b1) begin
                err_cnt      <= err_cnt + 1;
                last_err_cyc <= cyc;
            end
            if ((cmd.done === 1'b1 || cmd.err === 1'b1) &&
                (cmd.busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 ||
                 (cmd.done === 1'b1 && cmd.err === 1'b1)))
                pulse_viol <= pulse_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected data_oe after device edge k: D0..D7, odd parity, then released for the stop bit.
    function automatic logic exp_oe(input logic [7:0] b, input int k);
        logic par;
        par = (($countones(b) % 2) == 0);
        if (k >= 1 && k <= 8) return ~b[k-1];
        else if (k == 9)      return ~par;
        else                  return 1'b0;
    endfunction

    // Request a byte and verify the clock-inhibit and start-bit phase.
    task automatic start_and_inhibit(input logic [7:0] b);
        int n, start_n, guard;
        @(negedge clk);
        cmd.tx_data  = b;
        cmd.tx_start = 1'b1;
        @(negedge clk);
        cmd.tx_start = 1'b0;
        cmd.tx_data  = 8'($urandom);
        check("busy_after_start", {31'd0, cmd.busy}, 32'd1);
        n = 0; start_n = 0; guard = 0;
        while (ps2_clk_oe === 1'b1 && guard < INH + 50) begin
            n++;
            if (ps2_data_oe === 1'b1 && start_n == 0) begin
                start_n   = n;
                start_cyc = cyc;
            end
            @(negedge clk);
            guard++;
        end
        check("clk_oe_len", n, INH + 1);
        check("start_pos", start_n, INH + 1);
        check("start_bit_held", {31'd0, ps2_data_oe}, 32'd1);
    endtask

    task automatic txn(input logic [7:0] b, input bit ack, input int rst_edge, input bit repulse);
        int d0, e0, guard;
        bit aborted;
        d0 = done_cnt; e0 = err_cnt;
        start_and_inhibit(b);
        aborted = 1'b0;
        for (int k = 1; k <= 11 && !aborted; k++) begin
            repeat (HP - 2) @(negedge clk);
            if (k == 11 && ack) dev_data_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                check("rst_busy", {31'd0, cmd.busy}, 32'd0);
                rst = 1'b0;
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                aborted = 1'b1;
            end else begin
                if (repulse && k == 5) begin
                    cmd.tx_data  = 8'h00;
                    cmd.tx_start = 1'b1;
                    @(negedge clk);
                    cmd.tx_start = 1'b0;
                end
                repeat (HP) @(negedge clk);
                if (k <= 10) begin
                    check($sformatf("data_oe_edge%0d_byte%02h", k, b), {31'd0, ps2_data_oe}, {31'd0, exp_oe(b, k)});
                    check("clk_oe_in_tx", {31'd0, ps2_clk_oe}, 32'd0);
                end
                dev_clk_low = 1'b0;
                if (k == 11) dev_data_low = 1'b0;
            end
        end
        if (!aborted) begin
            guard = 0;
            while (done_cnt == d0 && err_cnt == e0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            repeat (3) @(negedge clk);
            check("done_pulses", done_cnt - d0, ack ? 32'd1 : 32'd0);
            check("err_pulses", err_cnt - e0, ack ? 32'd0 : 32'd1);
        end else begin
            repeat (10) @(negedge clk);
            check("rst_no_done", done_cnt - d0, 32'd0);
            check("rst_no_err", err_cnt - e0, 32'd0);
        end
        check("busy_end", {31'd0, cmd.busy}, 32'd0);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    task automatic timeout_txn(input logic [7:0] b);
        int d0, e0, guard;
        d0 = done_cnt; e0 = err_cnt;
        start_and_inhibit(b);
        guard = 0;
        while (err_cnt == e0 && done_cnt == d0 && guard < TO + 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("timeout_err", err_cnt - e0, 32'd1);
        check("timeout_no_done", done_cnt - d0, 32'd0);
        check("timeout_latency", last_err_cyc - start_cyc, TO);
        check("timeout_busy", {31'd0, cmd.busy}, 32'd0);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        cmd.tx_data  = 8'h00;
        cmd.tx_start = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, cmd.busy, cmd.done, cmd.err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {29'd0, ps2_clk_oe, ps2_data_oe, cmd.busy}, 32'd0);

        txn(PS2_CMD_ENABLE, 1'b1, 0, 1'b0);
        txn(PS2_CMD_RESET, 1'b1, 0, 1'b0);
        timeout_txn(PS2_CMD_ENABLE);
        txn(PS2_CMD_ENABLE, 1'b0, 0, 1'b0);
        txn(PS2_CMD_ENABLE, 1'b1, 0, 1'b1);
        txn(PS2_CMD_ENABLE, 1'b1, 5, 1'b0);
        txn(PS2_CMD_SET_RATE, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            txn(rb, ($urandom_range(0, 3) != 0), 0, 1'b0);
        end
        repeat (5) @(negedge clk);
        check("pulse_exclusive_and_idle", pulse_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
